pc_sequencer: RTL

Registered program-counter sequencer for the fetch stage, replacing the separate combinational next-PC and branch-target blocks with one parametrised unit. Holds the PC, computes the branch target from a word offset, resolves conditional (zero / non-zero), unconditional, call and return redirects, and keeps a circular return-address stack (RAS) of configurable depth. Sits between the decode/ALU outputs and the instruction memory address port.

---
 rtl/pc_sequencer_if.sv | 29 ++
 rtl/pc_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-stage control/status bundle between decode/ALU and the PC sequencer.
interface pc_sequencer_if #(
   parameter int unsigned WIDTH = 64
);
   logic             WriteEn;
   logic             Branch;
   logic             ZorNZ;
   logic             ALUZero;
   logic             Unconditional;
   logic             Call;
   logic             Return;
   logic [WIDTH-1:0] BranchOffset;
   logic [WIDTH-1:0] PC;
   logic [WIDTH-1:0] NextPC;
   logic             Taken;
   logic             RasEmpty;
   logic             RasFull;
   logic             RasFault;

   modport master (
      output WriteEn, Branch, ZorNZ, ALUZero, Unconditional, Call, Return, BranchOffset,
      input  PC, NextPC, Taken, RasEmpty, RasFull, RasFault
   );

   modport slave (
      input  WriteEn, Branch, ZorNZ, ALUZero, Unconditional, Call, Return, BranchOffset,
      output PC, NextPC, Taken, RasEmpty, RasFull, RasFault
   );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter with branch-target generation, redirect
// priority resolution and a circular return-address stack.
module pc_sequencer #(
   parameter int unsigned      WIDTH       = 64,
   parameter int unsigned      RAS_DEPTH   = 4,
   parameter logic [WIDTH-1:0] RESET_PC    = '0,
   parameter int unsigned      INSTR_BYTES = 4
) (
   input  logic          Clk,
   input  logic          Reset,
   pc_sequencer_if.slave bus
);
   localparam int unsigned      SHIFT   = $clog2(INSTR_BYTES);
   localparam int unsigned      PW      = $clog2(RAS_DEPTH);
   localparam logic [PW:0]      DEPTH_C = (PW+1)'(RAS_DEPTH);
   localparam logic [WIDTH-1:0] INCR    = WIDTH'(INSTR_BYTES);

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_ras [RAS_DEPTH];
   logic [PW-1:0]    r_top;
   logic [PW:0]      r_count;
   logic             r_empty;
   logic             r_full;
   logic             r_fault;

   logic [WIDTH-1:0] w_seq;
   logic [WIDTH-1:0] w_target;
   logic             w_cond;
   logic             w_ret_valid;
   logic [WIDTH-1:0] w_next_pc;
   logic             w_taken;
   logic [PW-1:0]    w_top_nx;
   logic [PW:0]      w_count_nx;
   logic             w_fault_nx;
   logic             w_ras_we;
   logic [PW-1:0]    w_ras_waddr;

   // Next-PC selection and return-stack next-state decode.
   always_comb begin
      w_seq       = r_pc + INCR;
      w_target    = r_pc + (bus.BranchOffset << SHIFT);
      w_cond      = bus.Branch & (bus.ZorNZ ? bus.ALUZero : ~bus.ALUZero);
      w_ret_valid = bus.Return & ~r_empty;

      w_next_pc   = r_pc;
      w_taken     = 1'b0;
      w_top_nx    = r_top;
      w_count_nx  = r_count;
      w_fault_nx  = 1'b0;
      w_ras_we    = 1'b0;
      w_ras_waddr = r_top;

      if (bus.WriteEn) begin
         if (w_ret_valid) begin
            w_next_pc = r_ras[r_top];
            w_taken   = 1'b1;
         end else if (bus.Call | bus.Unconditional | w_cond) begin
            w_next_pc = w_target;
            w_taken   = 1'b1;
         end else begin
            w_next_pc = w_seq;
         end

         // A Return on an empty stack is an underflow even when paired with Call.
         w_fault_nx = bus.Return & r_empty;

         if (bus.Call & w_ret_valid) begin
            // Call+Return swaps the top entry in place: depth is unchanged.
            w_ras_we    = 1'b1;
            w_ras_waddr = r_top;
         end else if (bus.Call) begin
            w_ras_we    = 1'b1;
            w_ras_waddr = r_top + PW'(1);
            w_top_nx    = r_top + PW'(1);
            if (r_full) begin
               w_fault_nx = 1'b1;
            end else begin
               w_count_nx = r_count + (PW+1)'(1);
            end
         end else if (w_ret_valid) begin
            w_top_nx   = r_top - PW'(1);
            w_count_nx = r_count - (PW+1)'(1);
         end
      end
   end

   // Return-address storage; contents survive reset, validity is tracked by the count.
   always_ff @(posedge Clk) begin
      if (!Reset && w_ras_we) begin
         r_ras[w_ras_waddr] <= w_seq;
      end
   end

   // PC, stack pointer/count and status flags.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_pc    <= RESET_PC;
         r_top   <= '0;
         r_count <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_fault <= w_fault_nx;
         if (bus.WriteEn) begin
            r_pc    <= w_next_pc;
            r_top   <= w_top_nx;
            r_count <= w_count_nx;
            r_empty <= (w_count_nx == '0);
            r_full  <= (w_count_nx == DEPTH_C);
         end
      end
   end

   assign bus.PC       = r_pc;
   assign bus.NextPC   = w_next_pc;
   assign bus.Taken    = w_taken;
   assign bus.RasEmpty = r_empty;
   assign bus.RasFull  = r_full;
   assign bus.RasFault = r_fault;
endmodule
